// File: rtl/fifo_pkg.sv
// Shared constants and pointer helpers for the 10-entry byte FIFO and its drain logic.
package fifo_pkg;

    localparam int DEPTH = 10;
    localparam int PTR_W = 4;
    localparam int DW    = 8;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH)) ? PTR_W'(1) : p + PTR_W'(1);
    endfunction

    // Pointers run 1..DEPTH, so equal pointers mean either empty or full.
    function automatic logic [PTR_W:0] occupancy(input logic [PTR_W-1:0] wr,
                                                 input logic [PTR_W-1:0] rd,
                                                 input logic             full);
        logic signed [PTR_W:0] diff;
        diff = $signed({1'b0, wr}) - $signed({1'b0, rd});
        if (diff < 0)
            diff = diff + $signed((PTR_W+1)'(DEPTH));
        if (wr == rd)
            return full ? (PTR_W+1)'(DEPTH) : '0;
        return $unsigned(diff);
    endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// Small circular output buffer presenting captured FIFO bytes on a valid/ready stream.
module fifo_rd_skid
    import fifo_pkg::*;
#(
    parameter int BUF_DEPTH = 2,
    localparam int IDX_W    = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1,
    localparam int CNT_W    = $clog2(BUF_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [DW-1:0]    i_din,
    output logic [DW-1:0]    o_m_data,
    output logic             o_m_valid,
    input  logic             i_m_ready,
    output logic [CNT_W-1:0] o_cnt
);

    logic [DW-1:0]    r_mem [BUF_DEPTH];
    logic [IDX_W-1:0] r_head;
    logic [IDX_W-1:0] r_tail;
    logic [CNT_W-1:0] r_cnt;
    logic             w_pop;

    function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] i);
        return (i == IDX_W'(BUF_DEPTH - 1)) ? '0 : i + IDX_W'(1);
    endfunction

    assign w_pop     = o_m_valid && i_m_ready;
    assign o_m_valid = (r_cnt != '0);
    assign o_m_data  = r_mem[r_head];
    assign o_cnt     = r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BUF_DEPTH; i++)
                r_mem[i] <= '0;
            r_head <= '0;
            r_tail <= '0;
            r_cnt  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_tail] <= i_din;
                r_tail        <= idx_inc(r_tail);
            end
            if (w_pop)
                r_head <= idx_inc(r_head);
            r_cnt <= r_cnt + CNT_W'(i_push) - CNT_W'(w_pop);
        end
    end

endmodule

// File: rtl/fifo_reader.sv
// Drain side of the byte FIFO: tracks fill level from the pointers, issues reads and streams bytes out.
module fifo_reader
    import fifo_pkg::*;
#(
    parameter int BUF_DEPTH = 2,
    localparam int CNT_W    = $clog2(BUF_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [PTR_W-1:0] wrptr,
    input  logic [PTR_W-1:0] rdptr,
    input  logic [DW-1:0]    fifo_dout,
    output logic             rd,
    output logic [DW-1:0]    m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [15:0]      byte_cnt
);

    logic [PTR_W-1:0] r_wr_prev;
    logic [PTR_W-1:0] r_rd_prev;
    logic             r_full;
    logic             r_rd_p0;
    logic             r_rd_p1;
    logic [15:0]      r_byte_cnt;

    logic             w_wr_chg;
    logic             w_rd_chg;
    logic [PTR_W:0]   w_occ;
    logic [CNT_W-1:0] w_buf_cnt;
    logic [CNT_W:0]   w_load;
    logic             w_pop;
    logic             w_issue;

    assign w_wr_chg = (wrptr != r_wr_prev);
    assign w_rd_chg = (rdptr != r_rd_prev);
    assign w_occ    = occupancy(wrptr, rdptr, r_full);
    assign w_pop    = m_valid && m_ready;

    // Slots already claimed: buffered bytes plus the read issued now and the one landing now.
    assign w_load   = {1'b0, w_buf_cnt} + (CNT_W+1)'(r_rd_p0) + (CNT_W+1)'(r_rd_p1)
                    - (CNT_W+1)'(w_pop);
    assign w_issue  = en && (w_occ > (PTR_W+1)'(r_rd_p0))
                    && (w_load < (CNT_W+1)'(BUF_DEPTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_prev  <= '0;
            r_rd_prev  <= '0;
            r_full     <= 1'b0;
            r_rd_p0    <= 1'b0;
            r_rd_p1    <= 1'b0;
            r_byte_cnt <= '0;
        end else begin
            r_wr_prev <= wrptr;
            r_rd_prev <= rdptr;
            if (w_wr_chg && !w_rd_chg && (wrptr == rdptr))
                r_full <= 1'b1;
            else if (w_rd_chg && !w_wr_chg)
                r_full <= 1'b0;
            // p0: read strobe to the FIFO; p1: its registered data is valid this cycle.
            r_rd_p0 <= w_issue;
            r_rd_p1 <= r_rd_p0;
            if (w_pop)
                r_byte_cnt <= r_byte_cnt + 16'd1;
        end
    end

    fifo_rd_skid #(.BUF_DEPTH(BUF_DEPTH)) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_push    (r_rd_p1),
        .i_din     (fifo_dout),
        .o_m_data  (m_data),
        .o_m_valid (m_valid),
        .i_m_ready (m_ready),
        .o_cnt     (w_buf_cnt)
    );

    assign rd       = r_rd_p0;
    assign byte_cnt = r_byte_cnt;

endmodule

// File: tb/tb_fifo_reader.sv
// Scoreboard bench for fifo_reader with a behavioural 10-entry FIFO on the read side.
module tb_fifo_reader;
    import fifo_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0;
    logic             m_ready = 1'b0;
    logic [PTR_W-1:0] wrptr;
    logic [PTR_W-1:0] rdptr;
    logic [DW-1:0]    fifo_dout;
    logic             rd;
    logic [DW-1:0]    m_data;
    logic             m_valid;
    logic [15:0]      byte_cnt;

    logic [DW-1:0]    mem [1:DEPTH];
    logic             fifo_rst = 1'b1;
    logic [DW-1:0]    exp_q [$];
    int               n_checks = 0;
    int               n_errors = 0;
    int               rd_pulses = 0;
    int               base;
    logic [DW-1:0]    first;

    always #5 clk = ~clk;

    fifo_reader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .wrptr     (wrptr),
        .rdptr     (rdptr),
        .fifo_dout (fifo_dout),
        .rd        (rd),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .byte_cnt  (byte_cnt)
    );

    // FIFO model: a read strobe advances rdptr and registers the head byte.
    always @(posedge clk) begin
        if (fifo_rst) begin
            rdptr     <= PTR_W'(1);
            fifo_dout <= '0;
        end else if (rd) begin
            fifo_dout <= mem[rdptr];
            rdptr     <= ptr_inc(rdptr);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr_byte(input logic [DW-1:0] b);
        tick(1);
        mem[wrptr] = b;
        wrptr      = ptr_inc(wrptr);
        exp_q.push_back(b);
    endtask

    task automatic wait_drain(input string tag, input int limit);
        for (int i = 0; i < limit; i++) begin
            if (exp_q.size() == 0) break;
            tick(1);
        end
        check(tag, exp_q.size(), 0);
        tick(4);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        wrptr = PTR_W'(1);
        for (int i = 1; i <= DEPTH; i++) mem[i] = '0;
        fork
            forever begin
                @(negedge clk);
                if (rst_n) begin
                    if (rd) rd_pulses++;
                    if (m_valid && m_ready) begin
                        if (exp_q.size() == 0)
                            check("extra_pop", {24'b0, m_data}, 32'h100);
                        else
                            check("m_data", {24'b0, m_data}, {24'b0, exp_q.pop_front()});
                    end
                end
            end
        join_none

        // Reset state
        tick(3);
        check("rst_rd", rd, 0);
        check("rst_valid", m_valid, 0);
        check("rst_data", m_data, 0);
        check("rst_cnt", byte_cnt, 0);
        fifo_rst = 1'b0;
        rst_n    = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            check("idle_rd", rd, 0);
            check("idle_valid", m_valid, 0);
        end
        check("idle_cnt", byte_cnt, 0);

        // Three bytes, free-flowing output
        en = 1'b1; m_ready = 1'b1; base = rd_pulses;
        wr_byte(8'hA1); wr_byte(8'hA2); wr_byte(8'hA3);
        wait_drain("t2_drain", 40);
        check("t2_pulses", rd_pulses - base, 3);
        check("t2_cnt", byte_cnt, 3);
        tick(5);
        check("t2_quiet", rd_pulses - base, 3);

        // Fill all ten entries, then drain across the pointer wrap
        en = 1'b0; base = rd_pulses;
        for (int i = 0; i < DEPTH; i++) wr_byte(DW'(8'h10 + i));
        tick(3);
        check("t3_no_rd", rd_pulses - base, 0);
        check("t3_no_valid", m_valid, 0);
        en = 1'b1;
        wait_drain("t3_drain", 80);
        check("t3_pulses", rd_pulses - base, 10);
        check("t3_cnt", byte_cnt, 13);
        tick(5);
        check("t3_quiet", rd_pulses - base, 10);

        // Backpressure: buffer limit caps reads at two
        m_ready = 1'b0; base = rd_pulses;
        for (int i = 0; i < 5; i++) wr_byte(DW'(8'h40 + i));
        tick(10);
        check("t4_pulses", rd_pulses - base, 2);
        check("t4_valid", m_valid, 1);
        first = exp_q[0];
        for (int i = 0; i < 4; i++) begin
            tick(1);
            check("t4_hold", m_data, first);
        end
        m_ready = 1'b1;
        wait_drain("t4_drain", 60);
        check("t4_pulses_all", rd_pulses - base, 5);
        check("t4_cnt", byte_cnt, 18);

        // en dropped while a read is in flight
        en = 1'b0; base = rd_pulses;
        wr_byte(8'h50); wr_byte(8'h51); wr_byte(8'h52);
        tick(2);
        en = 1'b1;
        for (int i = 0; i < 10 && !rd; i++) tick(1);
        check("t5_rd_seen", rd, 1);
        en = 1'b0;
        tick(10);
        check("t5_one_rd", rd_pulses - base, 1);
        check("t5_cnt", byte_cnt, 19);
        check("t5_left", exp_q.size(), 2);
        en = 1'b1;
        wait_drain("t5_drain", 40);
        check("t5_pulses", rd_pulses - base, 3);
        check("t5_cnt_all", byte_cnt, 21);

        // Reset in the middle of a transfer
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) wr_byte(DW'(8'h60 + i));
        tick(8);
        check("t6_buffered", m_valid, 1);
        rst_n = 1'b0; fifo_rst = 1'b1; wrptr = PTR_W'(1);
        exp_q.delete();
        #1;
        check("t6_async_valid", m_valid, 0);
        check("t6_async_rd", rd, 0);
        check("t6_async_cnt", byte_cnt, 0);
        tick(1);
        check("t6_rd", rd, 0);
        check("t6_valid", m_valid, 0);
        check("t6_data", m_data, 0);
        rst_n = 1'b1; fifo_rst = 1'b0;
        m_ready = 1'b1; base = rd_pulses;
        wr_byte(8'h70); wr_byte(8'h71);
        wait_drain("t6_drain", 40);
        check("t6_pulses", rd_pulses - base, 2);
        check("t6_cnt", byte_cnt, 2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
